// File: rtl/mdu_mul_seq.sv
// Iterative radix-4 Booth multiplier for RV64M MUL/MULH/MULHSU/MULHU/MULW.
// One Booth digit per cycle through a single encoder and one adder, with a held output handshake.

module booth_enc (
  input  logic [2:0] code,
  output logic       neg,
  output logic       one,
  output logic       two
);
  // 111 is encoded as +0, not -0, so no stray carry-in is added.
  assign one = code[1] ^ code[0];
  assign two = (code == 3'b011) | (code == 3'b100);
  assign neg = code[2] & ~(code[1] & code[0]);
endmodule

// state | meaning
// IDLE  | waiting for a request, in_ready high
// BUSY  | retiring one Booth digit per cycle
// DONE  | result held until out_ready or flush
module mdu_mul_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [1:0]      mul_op,
  input  logic            word,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);
  localparam int W    = XLEN + 2;
  localparam int ITER = W / 2;
  localparam int CW   = $clog2(ITER + 1);
  // Only the low 2*XLEN product bits are ever selected, so the sum is kept modulo 2^(2*XLEN).
  localparam int PW   = 2 * XLEN;
  localparam logic [CW-1:0] LAST_D = CW'(ITER - 1);
  localparam logic [CW-1:0] LAST_W = CW'(16);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [1:0]      op_q;
  logic            word_q;
  logic [CW-1:0]   cnt_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   x_q;
  logic [W:0]      y_q;

  logic [XLEN-1:0] a_in;
  logic [XLEN-1:0] b_in;
  logic            x_sgn;
  logic            y_sgn;
  logic            pp_neg;
  logic            pp_one;
  logic            pp_two;
  logic [PW-1:0]   pp;
  logic [PW-1:0]   sum;
  logic [XLEN-1:0] res_sel;
  logic            last;

  assign in_ready = (state == IDLE);

  assign a_in  = word ? {{(XLEN-32){src1[31]}}, src1[31:0]} : src1;
  assign b_in  = word ? {{(XLEN-32){src2[31]}}, src2[31:0]} : src2;
  assign x_sgn = (word | (mul_op == 2'b01) | (mul_op == 2'b10)) & a_in[XLEN-1];
  assign y_sgn = (word | (mul_op == 2'b01)) & b_in[XLEN-1];

  booth_enc u_enc (
    .code (y_q[2:0]),
    .neg  (pp_neg),
    .one  (pp_one),
    .two  (pp_two)
  );

  // X and Y shift by one digit per cycle, so digit i always sits at y_q[2:0] and x_q = X << 2i.
  always_comb begin
    pp = '0;
    if (pp_one)      pp = x_q;
    else if (pp_two) pp = {x_q[PW-2:0], 1'b0};
  end

  assign sum  = acc_q + (pp_neg ? ~pp : pp) + PW'(pp_neg);
  assign last = (cnt_q == (word_q ? LAST_W : LAST_D));

  always_comb begin
    if (word_q)               res_sel = {{(XLEN-32){sum[31]}}, sum[31:0]};
    else if (op_q == 2'b00)   res_sel = sum[XLEN-1:0];
    else                      res_sel = sum[PW-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      op_q      <= '0;
      word_q    <= 1'b0;
      cnt_q     <= '0;
      acc_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      cnt_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_q   <= mul_op;
            word_q <= word;
            x_q    <= {{(PW-XLEN){x_sgn}}, a_in};
            y_q    <= {{2{y_sgn}}, b_in, 1'b0};
            acc_q  <= '0;
            cnt_q  <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          acc_q <= sum;
          x_q   <= {x_q[PW-3:0], 2'b00};
          y_q   <= {2'b00, y_q[W:2]};
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= res_sel;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu_mul_seq.sv
// Directed bench for mdu_mul_seq: latency, product-half selection, backpressure, flush and reset.
module tb_mdu_mul_seq;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] src1;
  logic [63:0] src2;
  logic [1:0]  mul_op;
  logic        word;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;

  int total = 0;
  int bad   = 0;

  mdu_mul_seq #(.XLEN(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src1      (src1),
    .src2      (src2),
    .mul_op    (mul_op),
    .word      (word),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] ea, eb, p;
    if (w) begin
      ea = {{96{a[31]}}, a[31:0]};
      eb = {{96{b[31]}}, b[31:0]};
      p  = ea * eb;
      return {{32{p[31]}}, p[31:0]};
    end
    ea = (op == 2'b01 || op == 2'b10) ? {{64{a[63]}}, a} : {64'b0, a};
    eb = (op == 2'b01) ? {{64{b[63]}}, b} : {64'b0, b};
    p  = ea * eb;
    return (op == 2'b00) ? p[63:0] : p[127:64];
  endfunction

  task automatic issue(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    mul_op = op; word = w; src1 = a; src2 = b; in_valid = 1'b1;
    chk("issue_rdy", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    src1 = 64'hA5A5_5A5A_DEAD_BEEF;
    src2 = 64'h0F0F_F0F0_1234_5678;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run(input logic [1:0] op, input logic w, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] exp);
    int n;
    issue(op, w, a, b);
    wait_out(n);
    chk("latency", 64'(n + 1), w ? 64'd18 : 64'd34);
    chk("result", result, exp);
    @(posedge clk); #1;
    chk("rdy_after", 64'(in_ready), 64'd1);
    chk("vld_drop", 64'(out_valid), 64'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [63:0] cv [5];
    int n;
    int seen;
    cv[0] = 64'd0;
    cv[1] = 64'd1;
    cv[2] = 64'h8000_0000_0000_0000;
    cv[3] = 64'h7FFF_FFFF_FFFF_FFFF;
    cv[4] = 64'hFFFF_FFFF_FFFF_FFFF;

    rst_n = 1'b0; in_valid = 1'b0; src1 = '0; src2 = '0; mul_op = '0;
    word = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_res", result, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rst_rdy", 64'(in_ready), 64'd1);

    // basic and high-half signedness
    run(2'b00, 1'b0, 64'd3, 64'd5, 64'd15);
    run(2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    run(2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);
    run(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);

    // MULW, clean and with garbage upper bits
    run(2'b00, 1'b1, 64'h0000_0000_4000_0000, 64'd2, 64'hFFFF_FFFF_8000_0000);
    run(2'b11, 1'b1, 64'hDEAD_BEEF_4000_0000, 64'h1234_5678_0000_0002, 64'hFFFF_FFFF_8000_0000);

    // backpressure: hold 10 cycles while a new request waits
    out_ready = 1'b0;
    issue(2'b00, 1'b0, 64'd11, 64'd13);
    wait_out(n);
    chk("bp_latency", 64'(n + 1), 64'd34);
    @(negedge clk);
    in_valid = 1'b1; mul_op = 2'b00; word = 1'b0; src1 = 64'd2; src2 = 64'd9;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_res", result, 64'd143);
      chk("bp_vld", 64'(out_valid), 64'd1);
      chk("bp_rdy", 64'(in_ready), 64'd0);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_rel_vld", 64'(out_valid), 64'd0);
    chk("bp_rel_idle", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    chk("bp_next_acc", 64'(in_ready), 64'd0);
    in_valid = 1'b0; src1 = 64'hFFFF; src2 = 64'hFFFF;
    wait_out(n);
    chk("bp_next_lat", 64'(n + 1), 64'd34);
    chk("bp_next_res", result, 64'd18);
    @(posedge clk); #1;

    // flush at BUSY iteration 10
    issue(2'b00, 1'b0, 64'd100, 64'd200);
    repeat (10) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl_busy_vld", 64'(out_valid), 64'd0);
    chk("fl_busy_idle", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("fl_quiet", 64'(seen), 64'd0);
    run(2'b00, 1'b0, 64'd7, 64'd6, 64'd42);

    // request together with flush is not accepted
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; src1 = 64'd5; src2 = 64'd5; mul_op = 2'b00;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    chk("fl_noacc", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    chk("fl_noacc2", 64'(in_ready), 64'd1);

    // flush in DONE
    out_ready = 1'b0;
    issue(2'b00, 1'b0, 64'd3, 64'd3);
    wait_out(n);
    chk("fl_done_pre", 64'(out_valid), 64'd1);
    chk("fl_done_res", result, 64'd9);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl_done_vld", 64'(out_valid), 64'd0);
    chk("fl_done_idle", 64'(in_ready), 64'd1);
    out_ready = 1'b1;

    // asynchronous reset mid-BUSY
    issue(2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", 64'(out_valid), 64'd0);
    chk("arst_res", result, 64'd0);
    chk("arst_idle", 64'(in_ready), 64'd1);
    @(negedge clk) rst_n = 1'b1;
    run(2'b11, 1'b0, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 64'd1);

    // corner operand sweep; k==4 is MULW with mul_op deliberately set to MULHU
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 5; j++) begin
          if (k == 4) run(2'b11, 1'b1, cv[i], cv[j], ref_mul(2'b11, 1'b1, cv[i], cv[j]));
          else        run(2'(k), 1'b0, cv[i], cv[j], ref_mul(2'(k), 1'b0, cv[i], cv[j]));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
